// File: rtl/prog_mealy_pkg.sv
// Shared widths, legacy state codes and table-entry layout for prog_mealy_fsm.
package prog_mealy_pkg;

    localparam int STATE_W_D = 2;
    localparam int IN_W_D    = 1;
    localparam int OUT_W_D   = 3;
    localparam int CNT_W_D   = 8;

    localparam logic [1:0] ST_A = 2'b00;
    localparam logic [1:0] ST_B = 2'b01;
    localparam logic [1:0] ST_C = 2'b10;
    localparam logic [1:0] ST_D = 2'b11;

    typedef struct packed {
        logic [STATE_W_D-1:0] next;
        logic [OUT_W_D-1:0]   out;
    } entry_t;

    // Table index {state,in}; callers truncate to their address width.
    function automatic logic [15:0] mealy_idx(
        input logic [15:0] s,
        input logic [15:0] i,
        input int          in_w
    );
        return (s << in_w) | i;
    endfunction

endpackage

// File: rtl/mealy_table.sv
// Register-file transition/output table: one write port, one async read port.
module mealy_table
    import prog_mealy_pkg::*;
#(
    parameter int STATE_W = STATE_W_D,
    parameter int IN_W    = IN_W_D,
    parameter int OUT_W   = OUT_W_D
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_we,
    input  logic [STATE_W+IN_W-1:0] i_waddr,
    input  logic [STATE_W-1:0]      i_wnext,
    input  logic [OUT_W-1:0]        i_wout,
    input  logic [STATE_W+IN_W-1:0] i_raddr,
    output logic [STATE_W-1:0]      o_rnext,
    output logic [OUT_W-1:0]        o_rout
);

    localparam int N = 2 ** (STATE_W + IN_W);

    logic [STATE_W-1:0] r_next [N];
    logic [OUT_W-1:0]   r_out  [N];

    // Reset leaves every state self-looping with a zero output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < N; e++) begin
                r_next[e] <= STATE_W'(e >> IN_W);
                r_out[e]  <= '0;
            end
        end else if (i_we) begin
            r_next[i_waddr] <= i_wnext;
            r_out[i_waddr]  <= i_wout;
        end
    end

    assign o_rnext = r_next[i_raddr];
    assign o_rout  = r_out[i_raddr];

endmodule

// File: rtl/prog_mealy_fsm.sv
// Programmable Mealy FSM with valid/ready stepping and run-time table writes.
// Define PROG_MEALY_OUT_REG_EN to register out/out_valid (1-cycle latency).
module prog_mealy_fsm
    import prog_mealy_pkg::*;
#(
    parameter int STATE_W     = STATE_W_D,
    parameter int IN_W        = IN_W_D,
    parameter int OUT_W       = OUT_W_D,
    parameter int CNT_W       = CNT_W_D,
    parameter int RESET_STATE = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_we,
    input  logic [STATE_W+IN_W-1:0] cfg_addr,
    input  logic [STATE_W-1:0]      cfg_next,
    input  logic [OUT_W-1:0]        cfg_out,
    input  logic                    restart,
    input  logic                    step_valid,
    input  logic [IN_W-1:0]         in,
    output logic                    step_ready,
    output logic [STATE_W-1:0]      state,
    output logic [OUT_W-1:0]        out,
    output logic                    out_valid,
    output logic [CNT_W-1:0]        step_cnt
);

    localparam int                 ADDR_W  = STATE_W + IN_W;
    localparam logic [STATE_W-1:0] RST_ST  = STATE_W'(RESET_STATE);

    logic [STATE_W-1:0] r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]  w_idx;
    logic [STATE_W-1:0] w_next;
    logic [OUT_W-1:0]   w_rd_out;
    logic               w_accept;

    assign w_idx      = ADDR_W'(mealy_idx(16'(r_state), 16'(in), IN_W));
    assign step_ready = !cfg_we && !restart;
    assign w_accept   = step_valid && step_ready;

    mealy_table #(
        .STATE_W (STATE_W),
        .IN_W    (IN_W),
        .OUT_W   (OUT_W)
    ) u_table (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (cfg_we),
        .i_waddr (cfg_addr),
        .i_wnext (cfg_next),
        .i_wout  (cfg_out),
        .i_raddr (w_idx),
        .o_rnext (w_next),
        .o_rout  (w_rd_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RST_ST;
            r_cnt   <= '0;
        end else if (restart) begin
            r_state <= RST_ST;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_state <= w_next;
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign state    = r_state;
    assign step_cnt = r_cnt;

`ifdef PROG_MEALY_OUT_REG_EN
    logic [OUT_W-1:0] r_out;
    logic             r_out_valid;

    // Captures the pre-transition output; restart falls into the clear path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out       <= w_rd_out;
            r_out_valid <= 1'b1;
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
`else
    assign out       = w_rd_out;
    assign out_valid = step_valid;
`endif

endmodule

// File: tb/tb_prog_mealy_fsm.sv
// Directed self-checking bench for prog_mealy_fsm (legacy A/B/C/D table).
module tb_prog_mealy_fsm;
    import prog_mealy_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_we;
    logic [2:0] cfg_addr;
    logic [1:0] cfg_next;
    logic [2:0] cfg_out;
    logic       restart;
    logic       step_valid;
    logic       s_in;
    logic       step_ready;
    logic [1:0] s_state;
    logic [2:0] s_out;
    logic       out_valid;
    logic [7:0] step_cnt;

    int errors = 0;
    int checks = 0;

    logic [2:0] exp_out [8];

    always #5 clk = ~clk;

    prog_mealy_fsm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_next   (cfg_next),
        .cfg_out    (cfg_out),
        .restart    (restart),
        .step_valid (step_valid),
        .in         (s_in),
        .step_ready (step_ready),
        .state      (s_state),
        .out        (s_out),
        .out_valid  (out_valid),
        .step_cnt   (step_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [1:0] n,
                      input logic [2:0] o);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_next = n;
        cfg_out  = o;
        tick();
        cfg_we   = 1'b0;
    endtask

    initial begin
        exp_out = '{3'b111, 3'b101, 3'b001, 3'b011,
                    3'b000, 3'b100, 3'b110, 3'b110};
        rst_n      = 1'b0;
        cfg_we     = 1'b0;
        cfg_addr   = '0;
        cfg_next   = '0;
        cfg_out    = '0;
        restart    = 1'b0;
        step_valid = 1'b0;
        s_in       = 1'b0;
        #12;
        chk("rst_state", 32'(s_state), 32'(ST_A));
        chk("rst_cnt", 32'(step_cnt), 0);
        chk("rst_out", 32'(s_out), 0);
        chk("rst_ovalid", 32'(out_valid), 0);
        chk("rst_ready", 32'(step_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Load legacy table: in=1 advances, in=0 holds
        for (int e = 0; e < 8; e++) begin
            cfg_we   = 1'b1;
            cfg_addr = 3'(e);
            cfg_next = (e % 2 == 1) ? 2'(e / 2 + 1) : 2'(e / 2);
            cfg_out  = exp_out[e];
            step_valid = 1'b1;
            #1;
            if (e == 0) chk("load_ready", 32'(step_ready), 0);
            tick();
        end
        cfg_we = 1'b0;
        step_valid = 1'b0;
        #1;
        chk("load_nostep", 32'(s_state), 32'(ST_A));
        chk("load_cnt", 32'(step_cnt), 0);

        // Sweep each state, then advance with in=1
        for (int s = 0; s < 4; s++) begin
            step_valid = 1'b0;
            s_in = 1'b0;
            #1;
            chk("sweep_state", 32'(s_state), 32'(s));
`ifndef PROG_MEALY_OUT_REG_EN
            chk("sweep_out0", 32'(s_out), 32'(exp_out[2*s]));
            chk("sweep_ov0", 32'(out_valid), 0);
            step_valid = 1'b1;
            #1;
            chk("sweep_ov1", 32'(out_valid), 1);
`endif
            step_valid = 1'b1;
            s_in = 1'b1;
            #1;
`ifndef PROG_MEALY_OUT_REG_EN
            chk("sweep_out1", 32'(s_out), 32'(exp_out[2*s+1]));
`endif
            tick();
        end
        step_valid = 1'b0;
        #1;
        chk("ring_state", 32'(s_state), 32'(ST_A));
        chk("ring_cnt", 32'(step_cnt), 4);
        tick();
        chk("hold_state", 32'(s_state), 32'(ST_A));
        chk("hold_cnt", 32'(step_cnt), 4);

        // Write {B,1} while stepping from B
        step_valid = 1'b1;
        s_in = 1'b1;
        tick();
        chk("toB", 32'(s_state), 32'(ST_B));
        cfg_we = 1'b1;
        cfg_addr = 3'b011;
        cfg_next = ST_D;
        cfg_out = 3'b111;
        #1;
        chk("wr_ready", 32'(step_ready), 0);
`ifndef PROG_MEALY_OUT_REG_EN
        chk("wr_oldout", 32'(s_out), 32'(3'b011));
`endif
        tick();
        cfg_we = 1'b0;
        #1;
        chk("wr_stall", 32'(s_state), 32'(ST_B));
        chk("wr_stallcnt", 32'(step_cnt), 5);
        chk("wr_readyback", 32'(step_ready), 1);
`ifndef PROG_MEALY_OUT_REG_EN
        chk("wr_newout", 32'(s_out), 32'(3'b111));
`endif
        tick();
        chk("wr_toD", 32'(s_state), 32'(ST_D));
        chk("wr_cnt", 32'(step_cnt), 6);

        // D->A, restore {B,1}, A->B->C
        tick();
        chk("DtoA", 32'(s_state), 32'(ST_A));
        step_valid = 1'b0;
        wr(3'b011, ST_C, 3'b011);
        step_valid = 1'b1;
        tick();
        tick();
        chk("toC", 32'(s_state), 32'(ST_C));
        chk("toC_cnt", 32'(step_cnt), 9);
        restart = 1'b1;
        #1;
        chk("rs_ready", 32'(step_ready), 0);
        tick();
        restart = 1'b0;
        chk("rs_state", 32'(s_state), 32'(ST_A));
        chk("rs_cnt", 32'(step_cnt), 0);

        // Counter wrap: A with in=0 self-loops
        s_in = 1'b0;
        for (int k = 0; k < 255; k++) tick();
        chk("wrap_255", 32'(step_cnt), 255);
        tick();
        chk("wrap_0", 32'(step_cnt), 0);
        chk("wrap_state", 32'(s_state), 32'(ST_A));

        // Async reset mid-operation
        s_in = 1'b1;
        tick();
        chk("pre_rst", 32'(s_state), 32'(ST_B));
        rst_n = 1'b0;
        #1;
        chk("mrst_state", 32'(s_state), 32'(ST_A));
        chk("mrst_cnt", 32'(step_cnt), 0);
        chk("mrst_out1", 32'(s_out), 0);
        s_in = 1'b0;
        #1;
        chk("mrst_out0", 32'(s_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        s_in = 1'b1;
        tick();
        chk("selfloop_state", 32'(s_state), 32'(ST_A));
        chk("selfloop_cnt", 32'(step_cnt), 1);

`ifdef PROG_MEALY_OUT_REG_EN
        step_valid = 1'b0;
        wr(3'b000, ST_A, 3'b111);
        s_in = 1'b0;
        step_valid = 1'b1;
        #1;
        chk("reg_ov_pre", 32'(out_valid), 0);
        tick();
        step_valid = 1'b0;
        #1;
        chk("reg_out", 32'(s_out), 32'(3'b111));
        chk("reg_ov", 32'(out_valid), 1);
        tick();
        chk("reg_ov_drop", 32'(out_valid), 0);
        chk("reg_out_hold", 32'(s_out), 32'(3'b111));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prog_mealy_fsm.md
Name: prog_mealy_fsm

Overview:
- Clocked, programmable Mealy state machine; successor to the fixed 4-state (A/B/C/D) combinational Mealy output decoder.
- Holds its own state register and a run-time writable transition/output table indexed by {state, in}.
- Parametrised in state, input, output and counter widths.
- Sits between lab-level control logic and datapath enables; software/bench loads the table, then steps the machine with a valid/ready handshake.

Parameters:
- STATE_W, 2, state register width; number of states = 2**STATE_W
- IN_W, 1, input symbol width
- OUT_W, 3, Mealy output width
- CNT_W, 8, accepted-step counter width
- RESET_STATE, 0, state loaded on reset and on restart

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- cfg_we  in  1  table write strobe
- cfg_addr  in  STATE_W+IN_W  entry index {state,in}
- cfg_next  in  STATE_W  next-state field to write
- cfg_out  in  OUT_W  output field to write
- restart  in  1  synchronous return to RESET_STATE; table untouched
- step_valid  in  1  input symbol present
- in  in  IN_W  input symbol
- step_ready  out  1  step will be accepted this cycle
- state  out  STATE_W  current state
- out  out  OUT_W  Mealy output
- out_valid  out  1  out qualifies a presented symbol
- step_cnt  out  CNT_W  accepted steps since reset/restart

Behaviour:
- Reset (rst_n=0, async): state=RESET_STATE, step_cnt=0, every table entry e={s,i} set to next=s (self-loop), out=0. Outputs then: out=0, out_valid=0, step_ready=1.
- Table entry = {next[STATE_W], out[OUT_W]}, 2**(STATE_W+IN_W) entries, register storage.
- step_ready = !cfg_we && !restart.
- Accept = step_valid && step_ready; on accepting edge: state <= table[{state,in}].next; step_cnt <= step_cnt+1, wrapping modulo 2**CNT_W.
- out = table[{state,in}].out combinationally (true Mealy, zero latency); out_valid = step_valid.
- cfg_we: entry written at edge; new contents visible the following cycle. Reads in the write cycle return old contents. Step stalls during the write cycle.
- restart: at edge, state <= RESET_STATE and step_cnt <= 0. Wins over a simultaneous step (step not accepted). A concurrent cfg_we still writes.
- rst_n asserted mid-operation: immediate return to reset values, including the table; no partial step completes.
- step_valid=0: state and step_cnt hold.
- in or cfg_addr with X/unused bits: not permitted; no checking.

Optional Feature:
- Macro PROG_MEALY_OUT_REG_EN.
- Defined:
  - out and out_valid are registered: on an accepting edge, out <= table[{state,in}].out (pre-transition state) and out_valid <= 1; otherwise out_valid <= 0 and out holds.
  - Latency is 1 cycle after accept.
  - Reset value of out is 0; restart clears out_valid.
- Undefined: combinational behaviour as above.

Decomposition:
- Package prog_mealy_pkg:
  - default widths
  - legacy state encodings A=2'b00, B=2'b01, C=2'b10, D=2'b11
  - entry struct {next,out}
  - index helper function {state,in}
- Sub-module mealy_table: register-file storage with async reset, one write port and one combinational read port. The top holds the state register, counter, handshake and optional output register.

Test Plan:
- Reset then load the legacy table. out fields: A0=111, A1=101, B0=001, B1=011, C0=000, C1=100, D0=110, D1=110. next fields: in=1 → state+1, in=0 → hold. Then sweep state/in combinationally → each out matches; out_valid follows step_valid.
- From A, step in=1 four times → state A→B→C→D→A, step_cnt=4, out 101, 011, 100, 110 in sequence.
- Write entry {B,1} with next=D, out=111 while step_valid=1 → step_ready=0, no step that cycle; next cycle from B with in=1 → out=111, then state=D.
- restart and step_valid together in state C → state=A, step_cnt=0, no transition.
- Accept 256 steps with CNT_W=8 → step_cnt wraps to 0.
- rst_n low mid-sequence → state=A, step_cnt=0, all outs 0 with self-loops. With PROG_MEALY_OUT_REG_EN: step from A with in=0 → out=111 and out_valid=1 exactly one cycle later.
